// File: rtl/vga_pkg.sv
// Shared VGA-bus types and text-overlay geometry for the character drawing stage.
package vga_pkg;

    localparam int unsigned CNT_W           = 11;
    localparam int unsigned RGB_W           = 12;
    localparam int unsigned CHAR_W          = 8;
    localparam int unsigned CHAR_H          = 16;
    localparam int unsigned HOR_CHAR_NUMBER = 16;
    localparam int unsigned VER_CHAR_NUMBER = 16;
    localparam int unsigned RECT_W          = CHAR_W * HOR_CHAR_NUMBER;
    localparam int unsigned RECT_H          = CHAR_H * VER_CHAR_NUMBER;
    // Each ROM lookup is one registered cycle; the output register adds one more.
    localparam int unsigned ROM_PIPE        = 2;
    localparam int unsigned DRC_LATENCY     = ROM_PIPE + 2;

    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [RGB_W-1:0] rgb;
    } vga_if_t;

    // Payload carried alongside the ROM lookups until the glyph row arrives.
    typedef struct packed {
        vga_if_t    vga;
        logic       in_rect;
        logic [2:0] col;
    } drc_stage_t;

    localparam int unsigned DRC_STAGE_W = $bits(drc_stage_t);

endpackage

// File: rtl/draw_rect_char_if.sv
// VGA in/out bus plus char-ROM / font-ROM lookup signals of the text-overlay stage.
interface draw_rect_char_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] vcount_in;
    logic             vsync_in;
    logic             vblnk_in;
    logic [CNT_W-1:0] hcount_in;
    logic             hsync_in;
    logic             hblnk_in;
    logic [RGB_W-1:0] rgb_in;
    logic [7:0]       char_pixels;

    logic [7:0]       char_xy;
    logic [3:0]       char_line;
    logic [CNT_W-1:0] vcount_out;
    logic             vsync_out;
    logic             vblnk_out;
    logic [CNT_W-1:0] hcount_out;
    logic             hsync_out;
    logic             hblnk_out;
    logic [RGB_W-1:0] rgb_out;

    modport master (
        output vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in, char_pixels,
        input  char_xy, char_line, vcount_out, vsync_out, vblnk_out,
               hcount_out, hsync_out, hblnk_out, rgb_out
    );

    modport slave (
        input  vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in, char_pixels,
        output char_xy, char_line, vcount_out, vsync_out, vblnk_out,
               hcount_out, hsync_out, hblnk_out, rgb_out
    );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth register pipeline; every stage clears to zero on reset.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/draw_rect_char.sv
// Text overlay: addresses the char/font ROMs for a 128x256 px rectangle and paints
// the returned glyph rows over the VGA stream, which is delayed to stay aligned.
module draw_rect_char
    import vga_pkg::*;
#(
    parameter int unsigned      X_POS          = 0,
    parameter int unsigned      Y_POS          = 0,
    parameter logic [RGB_W-1:0] TEXT_COLOR     = 12'hFFF,
    parameter bit               BG_TRANSPARENT = 1'b1,
    parameter logic [RGB_W-1:0] BG_COLOR       = 12'h000
) (
    input  logic             clk,
    input  logic             rst_n,
    draw_rect_char_if.slave  vga
);

    logic [6:0]  w_x_off;
    logic [7:0]  w_y_off;
    logic        w_in_rect;
    vga_if_t     w_vga_in;
    drc_stage_t  w_stage_in;
    drc_stage_t  w_stage_d3;
    logic        w_pix_c;
    logic [RGB_W-1:0] w_rgb_c;
    vga_if_t     w_vga_next_c;

    logic [7:0]  r_char_xy;
    logic [3:0]  r_char_line_d1;
    logic [3:0]  r_char_line;
    vga_if_t     r_vga_out;

    // Only the low offset bits address the grid; they equal the low bits of the full subtraction.
    assign w_x_off = 7'(vga.hcount_in) - 7'(X_POS);
    assign w_y_off = 8'(vga.vcount_in) - 8'(Y_POS);

    // Compared against the raw counters so a wrapped offset can never look inside.
    assign w_in_rect = (32'(vga.hcount_in) >= X_POS) && (32'(vga.hcount_in) < X_POS + RECT_W) &&
                       (32'(vga.vcount_in) >= Y_POS) && (32'(vga.vcount_in) < Y_POS + RECT_H) &&
                       !vga.hblnk_in && !vga.vblnk_in;

    assign w_vga_in = '{vcount: vga.vcount_in, vsync: vga.vsync_in, vblnk: vga.vblnk_in,
                        hcount: vga.hcount_in, hsync: vga.hsync_in, hblnk: vga.hblnk_in,
                        rgb: vga.rgb_in};

    assign w_stage_in = '{vga: w_vga_in, in_rect: w_in_rect, col: w_x_off[2:0]};

    delay_line #(
        .WIDTH (DRC_STAGE_W),
        .DEPTH (ROM_PIPE + 1)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_stage_in),
        .o_data (w_stage_d3)
    );

    // char_line is held one extra cycle so it meets the char ROM's code at the font ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_xy      <= '0;
            r_char_line_d1 <= '0;
            r_char_line    <= '0;
        end else begin
            r_char_xy      <= {w_y_off[7:4], w_x_off[6:3]};
            r_char_line_d1 <= w_y_off[3:0];
            r_char_line    <= r_char_line_d1;
        end
    end

    always_comb begin
        w_pix_c      = vga.char_pixels[3'd7 - w_stage_d3.col];
        w_rgb_c      = w_stage_d3.vga.rgb;
        w_vga_next_c = w_stage_d3.vga;
        if (w_stage_d3.in_rect && w_pix_c) begin
            w_rgb_c = TEXT_COLOR;
        end else if (w_stage_d3.in_rect && !BG_TRANSPARENT) begin
            w_rgb_c = BG_COLOR;
        end
        w_vga_next_c.rgb = w_rgb_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_out <= '0;
        end else begin
            r_vga_out <= w_vga_next_c;
        end
    end

    assign vga.char_xy    = r_char_xy;
    assign vga.char_line  = r_char_line;
    assign vga.vcount_out = r_vga_out.vcount;
    assign vga.vsync_out  = r_vga_out.vsync;
    assign vga.vblnk_out  = r_vga_out.vblnk;
    assign vga.hcount_out = r_vga_out.hcount;
    assign vga.hsync_out  = r_vga_out.hsync;
    assign vga.hblnk_out  = r_vga_out.hblnk;
    assign vga.rgb_out    = r_vga_out.rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Directed bench for draw_rect_char: three parameterisations share one input stream,
// each with its own char-ROM / font-ROM model.
module tb_draw_rect_char;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        hb = 1'b0;
    logic        vb = 1'b0;
    logic [11:0] rgb = '0;

    bit          font_mode_const = 1'b0;
    logic [7:0]  font_const = '0;

    int n_checks = 0;
    int n_fail   = 0;

    draw_rect_char_if if0 ();
    draw_rect_char_if if1 ();
    draw_rect_char_if if2 ();

    draw_rect_char u_dut0 (.clk(clk), .rst_n(rst_n), .vga(if0));
    draw_rect_char #(.X_POS(100), .Y_POS(50)) u_dut1 (.clk(clk), .rst_n(rst_n), .vga(if1));
    draw_rect_char #(.BG_TRANSPARENT(1'b0), .BG_COLOR(12'h00F)) u_dut2 (.clk(clk), .rst_n(rst_n), .vga(if2));

    assign if0.vcount_in = vc;  assign if1.vcount_in = vc;  assign if2.vcount_in = vc;
    assign if0.vsync_in  = vs;  assign if1.vsync_in  = vs;  assign if2.vsync_in  = vs;
    assign if0.vblnk_in  = vb;  assign if1.vblnk_in  = vb;  assign if2.vblnk_in  = vb;
    assign if0.hcount_in = hc;  assign if1.hcount_in = hc;  assign if2.hcount_in = hc;
    assign if0.hsync_in  = hs;  assign if1.hsync_in  = hs;  assign if2.hsync_in  = hs;
    assign if0.hblnk_in  = hb;  assign if1.hblnk_in  = hb;  assign if2.hblnk_in  = hb;
    assign if0.rgb_in    = rgb; assign if1.rgb_in    = rgb; assign if2.rgb_in    = rgb;

    function automatic logic [7:0] char_rom(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    function automatic logic [7:0] font_rom(input logic [7:0] c, input logic [3:0] l);
        return c ^ {l, ~l} ^ 8'h3C;
    endfunction

    // One-cycle char ROM followed by one-cycle font ROM per DUT.
    logic [7:0] code0 = '0, code1 = '0, code2 = '0;
    always @(posedge clk) begin
        code0 <= char_rom(if0.char_xy);
        code1 <= char_rom(if1.char_xy);
        code2 <= char_rom(if2.char_xy);
        if0.char_pixels <= font_mode_const ? font_const : font_rom(code0, if0.char_line);
        if1.char_pixels <= font_mode_const ? font_const : font_rom(code1, if1.char_line);
        if2.char_pixels <= font_mode_const ? font_const : font_rom(code2, if2.char_line);
    end

    function automatic logic [11:0] exp_rgb(input int x0, input int y0, input bit transp,
                                            input logic [11:0] bg, input vga_if_t p);
        logic        in_r;
        logic [10:0] xo, yo;
        logic [7:0]  pix;
        int          idx;
        in_r = (int'(p.hcount) >= x0) && (int'(p.hcount) < x0 + 128) &&
               (int'(p.vcount) >= y0) && (int'(p.vcount) < y0 + 256) && !p.hblnk && !p.vblnk;
        xo  = p.hcount - 11'(x0);
        yo  = p.vcount - 11'(y0);
        pix = font_rom(char_rom({yo[7:4], xo[6:3]}), yo[3:0]);
        idx = 7 - int'(xo[2:0]);
        if (in_r && pix[idx]) return 12'hFFF;
        if (in_r && !transp) return bg;
        return p.rgb;
    endfunction

    task automatic drive(input int h, input int v, input logic s_h, input logic s_v,
                         input logic b_h, input logic b_v, input logic [11:0] c);
        hc = 11'(h); vc = 11'(v); hs = s_h; vs = s_v; hb = b_h; vb = b_v; rgb = c;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if0.rgb_out, if0.hcount_out, if0.vcount_out, if0.char_xy, if0.char_line} !== '0) begin
            n_fail++; $display("FAIL reset_initial: got rgb=%h h=%0d v=%0d xy=%h, want all 0",
                               if0.rgb_out, if0.hcount_out, if0.vcount_out, if0.char_xy);
        end
        rst_n = 1'b1;
        drive(500, 300, 1'b1, 1'b1, 1'b1, 1'b0, 12'hABC);
        repeat (6) @(negedge clk);
        n_checks++;
        if (if0.char_xy !== 8'h2E || if0.hcount_out !== 11'd500 || if0.rgb_out !== 12'hABC) begin
            n_fail++; $display("FAIL pre_reset: got xy=%h h=%0d rgb=%h, want xy=2e h=500 rgb=abc",
                               if0.char_xy, if0.hcount_out, if0.rgb_out);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if0.rgb_out, if0.hcount_out, if0.vcount_out, if0.hsync_out, if0.vsync_out,
             if0.hblnk_out, if0.vblnk_out, if0.char_xy, if0.char_line} !== '0) begin
            n_fail++; $display("FAIL reset_async: got rgb=%h h=%0d hs=%b xy=%h line=%h, want all 0",
                               if0.rgb_out, if0.hcount_out, if0.hsync_out, if0.char_xy, if0.char_line);
        end
        repeat (3) @(negedge clk);
        drive(900, 10, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < 4) begin
                if (if0.hcount_out !== 11'd0 || if0.rgb_out !== 12'h0 || if0.hsync_out !== 1'b0) begin
                    n_fail++; $display("FAIL refill_zero[%0d]: got h=%0d rgb=%h hs=%b, want 0",
                                       k, if0.hcount_out, if0.rgb_out, if0.hsync_out);
                end
            end else if (if0.hcount_out !== 11'd900 || if0.vcount_out !== 11'd10 ||
                         if0.rgb_out !== 12'h123 || if0.hsync_out !== 1'b1 || if0.hblnk_out !== 1'b1) begin
                n_fail++; $display("FAIL refill_first: got h=%0d v=%0d rgb=%h hs=%b hb=%b, want 900 10 123 1 1",
                                   if0.hcount_out, if0.vcount_out, if0.rgb_out, if0.hsync_out, if0.hblnk_out);
            end
        end
    endtask

    task automatic test_char_addr();
        @(negedge clk);
        drive(19, 37, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        n_checks++;
        if (if0.char_xy !== 8'h22) begin
            n_fail++; $display("FAIL char_xy_19_37: got %h want 22", if0.char_xy);
        end
        @(negedge clk);
        n_checks++;
        if (if0.char_line !== 4'h5) begin
            n_fail++; $display("FAIL char_line_19_37: got %h want 5", if0.char_line);
        end
        drive(127, 255, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        n_checks++;
        if (if0.char_xy !== 8'hFF || if1.char_xy !== 8'hC3) begin
            n_fail++; $display("FAIL char_xy_corner: got %h/%h want ff/c3", if0.char_xy, if1.char_xy);
        end
        @(negedge clk);
        n_checks++;
        if (if0.char_line !== 4'hF || if1.char_line !== 4'hD) begin
            n_fail++; $display("FAIL char_line_corner: got %h/%h want f/d", if0.char_line, if1.char_line);
        end
    endtask

    task automatic test_glyph_col();
        int          vh [4] = '{8, 9, 127, 128};
        logic [11:0] vr [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
        logic [11:0] ve [4] = '{12'hFFF, 12'h456, 12'h789, 12'hABC};
        font_mode_const = 1'b1;
        font_const      = 8'h80;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                n_checks++;
                if (if0.rgb_out !== ve[k-4] || if0.hcount_out !== 11'(vh[k-4])) begin
                    n_fail++; $display("FAIL glyph_col h=%0d: got rgb=%h h=%0d want rgb=%h",
                                       vh[k-4], if0.rgb_out, if0.hcount_out, ve[k-4]);
                end
            end
            if (k < 4) drive(vh[k], 5, 1'b0, 1'b0, 1'b0, 1'b0, vr[k]);
            else       drive(1000, 1000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        end
    endtask

    task automatic test_offset_rect();
        int          vh [7] = '{99, 100, 227, 228, 150, 150, 150};
        int          vv [7] = '{60, 60, 60, 60, 49, 305, 306};
        logic [11:0] vr [7] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777};
        logic [11:0] ve [7] = '{12'h111, 12'hFFF, 12'hFFF, 12'h444, 12'h555, 12'hFFF, 12'h777};
        font_mode_const = 1'b1;
        font_const      = 8'hFF;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                n_checks++;
                if (if1.rgb_out !== ve[k-4]) begin
                    n_fail++; $display("FAIL offset_rect h=%0d v=%0d: got %h want %h",
                                       vh[k-4], vv[k-4], if1.rgb_out, ve[k-4]);
                end
            end
            if (k < 7) drive(vh[k], vv[k], 1'b0, 1'b0, 1'b0, 1'b0, vr[k]);
            else       drive(1000, 1000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        end
    endtask

    task automatic test_opaque_bg();
        int          vh [5] = '{10, 10, 10, 200, 127};
        int          vv [5] = '{10, 10, 10, 10, 255};
        logic        bh [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        bv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] vr [5] = '{12'hABC, 12'hABC, 12'hDEF, 12'h321, 12'h654};
        logic [11:0] ve [5] = '{12'h00F, 12'hABC, 12'hDEF, 12'h321, 12'h00F};
        font_mode_const = 1'b1;
        font_const      = 8'h00;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                n_checks++;
                if (if2.rgb_out !== ve[k-4]) begin
                    n_fail++; $display("FAIL opaque_bg vec%0d: got %h want %h", k - 4, if2.rgb_out, ve[k-4]);
                end
            end
            if (k < 5) drive(vh[k], vv[k], 1'b0, 1'b0, bh[k], bv[k], vr[k]);
            else       drive(1000, 1000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        end
    endtask

    // Reduced frame (224 x 264 with blanking/sync) streamed through all three DUTs.
    task automatic test_frame_scan();
        vga_if_t hist [4];
        vga_if_t cur;
        int      k = 0;
        font_mode_const = 1'b0;
        for (int v = 0; v < 264; v++) begin
            for (int h = 0; h < 224; h++) begin
                @(negedge clk);
                if (k >= 4) begin
                    n_checks++;
                    if (if0.rgb_out !== exp_rgb(0, 0, 1'b1, 12'h000, hist[3])) begin
                        n_fail++; $display("FAIL scan_dut0 h=%0d v=%0d: got %h want %h", hist[3].hcount,
                                           hist[3].vcount, if0.rgb_out, exp_rgb(0, 0, 1'b1, 12'h000, hist[3]));
                    end
                    n_checks++;
                    if (if1.rgb_out !== exp_rgb(100, 50, 1'b1, 12'h000, hist[3])) begin
                        n_fail++; $display("FAIL scan_dut1 h=%0d v=%0d: got %h want %h", hist[3].hcount,
                                           hist[3].vcount, if1.rgb_out, exp_rgb(100, 50, 1'b1, 12'h000, hist[3]));
                    end
                    n_checks++;
                    if (if2.rgb_out !== exp_rgb(0, 0, 1'b0, 12'h00F, hist[3])) begin
                        n_fail++; $display("FAIL scan_dut2 h=%0d v=%0d: got %h want %h", hist[3].hcount,
                                           hist[3].vcount, if2.rgb_out, exp_rgb(0, 0, 1'b0, 12'h00F, hist[3]));
                    end
                    n_checks++;
                    if ({if0.vcount_out, if0.vsync_out, if0.vblnk_out, if0.hcount_out, if0.hsync_out, if0.hblnk_out} !==
                        {hist[3].vcount, hist[3].vsync, hist[3].vblnk, hist[3].hcount, hist[3].hsync, hist[3].hblnk}) begin
                        n_fail++; $display("FAIL scan_timing: got v=%0d vs=%b h=%0d hs=%b want v=%0d vs=%b h=%0d hs=%b",
                                           if0.vcount_out, if0.vsync_out, if0.hcount_out, if0.hsync_out,
                                           hist[3].vcount, hist[3].vsync, hist[3].hcount, hist[3].hsync);
                    end
                end
                cur.hcount = 11'(h);
                cur.vcount = 11'(v);
                cur.hblnk  = (h >= 200);
                cur.hsync  = (h >= 204) && (h < 212);
                cur.vblnk  = (v >= 260);
                cur.vsync  = (v >= 261) && (v < 263);
                cur.rgb    = {cur.hcount[3:0] ^ cur.vcount[7:4], cur.vcount[3:0], cur.hcount[7:4]};
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = cur;
                drive(h, v, cur.hsync, cur.vsync, cur.hblnk, cur.vblnk, cur.rgb);
                k++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_char_addr();
        test_glyph_col();
        test_offset_rect();
        test_opaque_bg();
        test_frame_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_rect_char.md
Name: draw_rect_char

Overview:
- Text-overlay stage wrapped around the 16x16 character ROM.
- Takes the VGA timing/RGB bus and, when the beam is inside a 128x256 px text rectangle, generates `char_xy` (character cell address) and `char_line` (glyph row).
- The ROM returns the character code. The font ROM returns one 8-bit glyph row in `char_pixels`, and this block paints it over the incoming RGB.
- The VGA bus is delayed internally to stay aligned with the two registered ROM lookups.

Parameters:
- `X_POS`, 0, left edge of text rectangle in pixels.
- `Y_POS`, 0, top edge of text rectangle in pixels.
- `TEXT_COLOR`, 12'hFFF, RGB444 colour of set glyph pixels.
- `BG_TRANSPARENT`, 1, 1: unset glyph pixels pass input RGB; 0: paint them `BG_COLOR`.
- `BG_COLOR`, 12'h000, background colour used when `BG_TRANSPARENT`=0.

Ports:
- `clk` in 1 pixel clock.
- `rst_n` in 1 asynchronous active-low reset.
- `vcount_in` in 11 vertical counter.
- `vsync_in` in 1 vertical sync.
- `vblnk_in` in 1 vertical blank.
- `hcount_in` in 11 horizontal counter.
- `hsync_in` in 1 horizontal sync.
- `hblnk_in` in 1 horizontal blank.
- `rgb_in` in 12 input colour.
- `char_pixels` in 8 glyph row from font ROM, MSB = leftmost pixel.
- `char_xy` out 8 `[7:4]` cell row, `[3:0]` cell column, to char ROM.
- `char_line` out 4 glyph row index, to font ROM.
- `vcount_out`, `vsync_out`, `vblnk_out`, `hcount_out`, `hsync_out`, `hblnk_out`, `rgb_out` out (widths as inputs) delayed/overlaid VGA bus.

Behaviour:
- Reset (`rst_n`=0, async): every output register and every internal pipeline register clears to 0, including `char_xy`, `char_line` and the whole VGA bus. The pipeline refills after release; the first 4 output cycles are zero.
- Geometry, from `vga_pkg`:
  - Cell size is `CHAR_W`=8 x `CHAR_H`=16.
  - Grid is `HOR_CHAR_NUMBER`=16 x `VER_CHAR_NUMBER`=16.
  - Rectangle width is `RECT_W`=128 and height is `RECT_H`=256.
- `x_off = hcount_in - X_POS`, `y_off = vcount_in - Y_POS`, both 11-bit unsigned.
- `in_rect` = `hcount_in` in [`X_POS`, `X_POS`+127], `vcount_in` in [`Y_POS`, `Y_POS`+255], and neither blank active. Compare against the un-subtracted counts so wrap-around never gives a false hit.
- Pipeline, with inputs sampled at edge T:
  - T+1: `char_xy` <= {`y_off[7:4]`, `x_off[6:3]`}; `char_line_d1` <= `y_off[3:0]`; latch `in_rect`, `x_off[2:0]` and the VGA bus into delay stage 1.
  - T+2: the char ROM presents `char_code`. `char_line` output <= `char_line_d1`, so it is aligned with `char_code`. Delay stage 2.
  - T+3: the font ROM presents `char_pixels`. Delay stage 3.
  - T+4: outputs are registered.
    - If delayed `in_rect` and `char_pixels[7 - col_d3]` = 1: `rgb_out` = `TEXT_COLOR`.
    - Else if delayed `in_rect` and `BG_TRANSPARENT`=0: `rgb_out` = `BG_COLOR`.
    - Else: `rgb_out` = delayed `rgb_in`.
  - All timing outputs equal their inputs delayed exactly 4 cycles.
- Outside the rectangle, `char_xy` and `char_line` still update from the (wrapped) offsets. Their values are don't-care because `in_rect` masks the result.
- Rectangle partly off-screen (e.g. `X_POS`+127 > 799): the visible part renders correctly and the blanking mask suppresses the rest.
- Counter roll-over (`hcount` 1055 -> 0) needs no special handling; each pixel is independent.
- The ROM latencies are fixed at 1 cycle each. A different latency requires changing the delay depth constant `ROM_PIPE`=2 (total latency `ROM_PIPE`+2).

Decomposition:
- `vga_pkg` holds `CHAR_W`, `CHAR_H`, `HOR_CHAR_NUMBER`, `VER_CHAR_NUMBER`, `RECT_W`, `RECT_H`, and `DRC_LATENCY`=4.
- A `vga_if_t` struct (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb) is added to `vga_pkg`.
- One sub-module, `delay_line` (parameters `WIDTH`, `DEPTH`, async active-low reset, clears to 0), carries the `vga_if_t` bus, `in_rect` and the column bits.

Test Plan:
1. Reset asserted mid-frame for 3 cycles -> all outputs 0 immediately (async). After release, output equals input delayed 4 cycles.
2. `X_POS`=0, `Y_POS`=0, inputs `hcount`=19, `vcount`=37 -> `char_xy`=8'h22 and `char_line`=4'h5 (`char_line` one cycle after `char_xy`).
3. Font model returns `char_pixels`=8'b1000_0000 for all codes, at `hcount`=8 and `hcount`=9 (`X_POS`=0) -> `rgb_out`=`TEXT_COLOR` for `hcount_out`=8, passthrough `rgb_in` for 9, both 4 cycles later.
4. `X_POS`=100, `Y_POS`=50, `hcount`=99 or 228 -> `rgb_out`=`rgb_in` (outside). `hcount`=100 and 227 with `char_pixels`=8'hFF -> `TEXT_COLOR`.
5. `BG_TRANSPARENT`=0, `BG_COLOR`=12'h00F, `char_pixels`=0 inside rect -> `rgb_out`=12'h00F. During `hblnk`=1 -> `rgb_in` passthrough.
6. Full 800x600 frame against the char-ROM and font-ROM models -> pixel-exact match with a reference image. `hsync_out` and `vsync_out` edges occur exactly 4 cycles after the input edges.
